// File: rtl/onehot_pkg.sv
// Shared widths, types and stage-1 payload for the 1024-to-10 pipelined one-hot encoder.
package onehot_pkg;

  localparam int unsigned IN_W   = 10;
  localparam int unsigned OUT_W  = 1024;
  localparam int unsigned GRP_W  = 32;
  localparam int unsigned GW     = 5;
  localparam int unsigned NGRP   = OUT_W / GRP_W;
  localparam int unsigned GSEL_W = IN_W - GW;

  typedef logic [IN_W-1:0] idx_t;
  typedef logic [GW-1:0]   grp_idx_t;

  // Per-group summary captured in stage 1.
  typedef struct packed {
    logic [NGRP-1:0]            any;
    logic [NGRP-1:0]            multi;
    logic [NGRP-1:0][GW-1:0]    lo;
  } s1_t;

  // Constant consistency check for the chosen widths.
  function automatic bit widths_ok();
    return (OUT_W == (32'd1 << IN_W)) && (GRP_W == (32'd1 << GW)) &&
           (NGRP * GRP_W == OUT_W);
  endfunction

endpackage

// File: rtl/onehot_grp_enc.sv
// Combinational encoder for one GRP_W-bit group: any bit set, more than one set, lowest set index.
module onehot_grp_enc
  import onehot_pkg::*;
(
  input  logic [GRP_W-1:0] grp_i,
  output logic             any_c,
  output logic             multi_c,
  output grp_idx_t         lo_c
);

  assign any_c   = |grp_i;
  assign multi_c = |(grp_i & (grp_i - GRP_W'(1)));

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    lo_c = '0;
    for (int i = GRP_W - 1; i >= 0; i--) begin
      if (grp_i[i]) lo_c = GW'(i);
    end
  end

endmodule

// File: rtl/onehot_encoder_pipe.sv
// Two-stage 1024-to-10 one-hot encoder with valid/ready flow control and not-one-hot flagging.
module onehot_encoder_pipe
  import onehot_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OUT_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output idx_t             out_idx,
  output logic             out_err,
  output logic             out_zero,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [NGRP-1:0]          any_c;
  logic [NGRP-1:0]          multi_c;
  logic [NGRP-1:0][GW-1:0]  lo_c;
  s1_t                      enc_c;

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    onehot_grp_enc u_enc (
      .grp_i   (in_data[g*GRP_W +: GRP_W]),
      .any_c   (any_c[g]),
      .multi_c (multi_c[g]),
      .lo_c    (lo_c[g])
    );
  end

  assign enc_c = '{any: any_c, multi: multi_c, lo: lo_c};

  logic s1_valid_q, s1_valid_d;
  s1_t  s1_q, s1_d;
  logic out_valid_q, out_valid_d;
  idx_t out_idx_q, out_idx_d;
  logic out_err_q, out_err_d;
  logic out_zero_q, out_zero_d;

  logic s2_adv_c;
  logic s1_adv_c;

  assign s2_adv_c = !out_valid_q || out_ready;
  assign s1_adv_c = !s1_valid_q || s2_adv_c;
  assign in_ready = s1_adv_c;

  // Stage-2 combine: pick the lowest populated group and judge one-hotness.
  logic [GSEL_W-1:0] gsel_c;
  logic              zero_c;
  logic              err_c;
  idx_t              idx_c;

  always_comb begin
    gsel_c = '0;
    for (int g = NGRP - 1; g >= 0; g--) begin
      if (s1_q.any[g]) gsel_c = GSEL_W'(g);
    end
    zero_c = ~|s1_q.any;
    err_c  = zero_c || (|s1_q.multi) || (|(s1_q.any & (s1_q.any - NGRP'(1))));
    idx_c  = zero_c ? '0 : {gsel_c, s1_q.lo[gsel_c]};
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_err_d   = out_err_q;
    out_zero_d  = out_zero_q;
    if (s1_adv_c) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_d = enc_c;
    end
    if (s2_adv_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_idx_d  = idx_c;
        out_err_d  = err_c;
        out_zero_d = zero_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_err_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_err_q   <= out_err_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_err   = out_err_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Directed and randomized bench for onehot_encoder_pipe with a queue-based reference model.
module tb_onehot_encoder_pipe;
  import onehot_pkg::*;

  logic             clk;
  logic             rst_n;
  logic [OUT_W-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  idx_t             out_idx;
  logic             out_err;
  logic             out_zero;
  logic             out_valid;
  logic             out_ready;

  onehot_encoder_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_idx   (out_idx),
    .out_err   (out_err),
    .out_zero  (out_zero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    idx_t idx;
    logic err;
    logic zero;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;

  // Reference: lowest set index by scanning, popcount by counting ones.
  function automatic exp_t ref_model(input logic [OUT_W-1:0] d);
    exp_t e;
    int   pc;
    pc     = $countones(d);
    e.zero = (pc == 0);
    e.err  = (pc != 1);
    e.idx  = '0;
    for (int i = 0; i < int'(OUT_W); i++) begin
      if (d[i]) begin
        e.idx = idx_t'(i);
        break;
      end
    end
    return e;
  endfunction

  function automatic logic [OUT_W-1:0] bit_vec(input int k);
    logic [OUT_W-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, score any output transfer, log any input transfer.
  task automatic cyc(input logic v, input logic [OUT_W-1:0] d, input logic r);
    exp_t e;
    logic in_fire, out_fire;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    in_fire  = v && in_ready;
    out_fire = out_valid && r;
    if (out_fire) begin
      n_out++;
      n_cmp++;
      assert (q.size() > 0) else begin
        n_err++;
        $error("FAIL sb_unexpected: observed output idx %0d expected none", out_idx);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_idx",  32'(out_idx),  32'(e.idx));
        chk("sb_err",  32'(out_err),  32'(e.err));
        chk("sb_zero", 32'(out_zero), 32'(e.zero));
      end
    end
    if (in_fire) q.push_back(ref_model(d));
    @(posedge clk);
  endtask

  task automatic send_and_check(input string tag, input logic [OUT_W-1:0] d,
                                input int exp_idx, input logic exp_err, input logic exp_zero);
    cyc(1'b1, d, 1'b1);
    cyc(1'b0, '0, 1'b1);
    #2;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_idx"},   32'(out_idx),   32'(exp_idx));
    chk({tag, "_err"},   32'(out_err),   32'(exp_err));
    chk({tag, "_zero"},  32'(out_zero),  32'(exp_zero));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int               base;
    logic [OUT_W-1:0] d;
    logic             v, r;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_idx",   32'(out_idx),   32'd0);
    chk("rst_err",   32'(out_err),   32'd0);
    chk("rst_zero",  32'(out_zero),  32'd0);
    chk("rst_ready", 32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Two-cycle latency on the first vector.
    cyc(1'b1, bit_vec(0), 1'b1);
    #2;
    chk("lat_c1_valid", 32'(out_valid), 32'd0);
    cyc(1'b0, '0, 1'b1);
    #2;
    chk("lat_c2_valid", 32'(out_valid), 32'd1);
    chk("lat_c2_idx",   32'(out_idx),   32'd0);
    chk("lat_c2_err",   32'(out_err),   32'd0);
    chk("lat_c2_zero",  32'(out_zero),  32'd0);
    cyc(1'b0, '0, 1'b1);

    // Back-to-back sweep of every one-hot vector.
    base = n_out;
    for (int k = 0; k < int'(OUT_W); k++) begin
      cyc(1'b1, bit_vec(k), 1'b1);
      #2;
      if (k >= 1) begin
        chk("sweep_valid", 32'(out_valid), 32'd1);
        chk("sweep_idx",   32'(out_idx),   32'(k - 1));
      end
    end
    repeat (3) cyc(1'b0, '0, 1'b1);
    chk("sweep_count", 32'(n_out - base), 32'(OUT_W));

    // Corrupted vectors.
    send_and_check("zero", '0, 0, 1'b1, 1'b1);
    send_and_check("two_grp", bit_vec(5) | bit_vec(700), 5, 1'b1, 1'b0);
    send_and_check("same_grp", bit_vec(33) | bit_vec(34), 33, 1'b1, 1'b0);
    send_and_check("top_bit", bit_vec(1023), 1023, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b1);

    // Backpressure: both stages fill, output holds, then drains in order.
    base = n_out;
    cyc(1'b1, bit_vec(100), 1'b0);
    cyc(1'b1, bit_vec(200), 1'b0);
    #2;
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_idx",   32'(out_idx),   32'd100);
    chk("bp_ready", 32'(in_ready),  32'd0);
    repeat (3) begin
      cyc(1'b1, bit_vec(300), 1'b0);
      #2;
      chk("bp_hold_idx",   32'(out_idx),  32'd100);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    cyc(1'b1, bit_vec(300), 1'b1);
    repeat (4) cyc(1'b0, '0, 1'b1);
    chk("bp_count", 32'(n_out - base), 32'd3);
    chk("bp_drain", 32'(q.size()), 32'd0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 10000; n++) begin
      d = '0;
      case ($urandom_range(0, 4))
        0, 1: d = bit_vec(int'($urandom_range(0, OUT_W - 1)));
        2: begin
          repeat ($urandom_range(1, 4)) d[$urandom_range(0, OUT_W - 1)] = 1'b1;
        end
        3: begin
          for (int w = 0; w < int'(NGRP); w++) d[w*32 +: 32] = $urandom;
        end
        default: d = '0;
      endcase
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 7);
      cyc(v, d, r);
    end
    repeat (4) cyc(1'b0, '0, 1'b1);
    chk("rand_drain", 32'(q.size()), 32'd0);

    // Async reset with both stages full drops everything in flight.
    cyc(1'b1, bit_vec(11), 1'b0);
    cyc(1'b1, bit_vec(22), 1'b0);
    #2;
    chk("ar_full_valid", 32'(out_valid), 32'd1);
    chk("ar_full_ready", 32'(in_ready),  32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_valid_now", 32'(out_valid), 32'd0);
    q.delete();
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    base = n_out;
    repeat (4) begin
      cyc(1'b0, '0, 1'b1);
      #2;
      chk("ar_quiet", 32'(out_valid), 32'd0);
    end
    chk("ar_no_out", 32'(n_out - base), 32'd0);
    send_and_check("ar_new", bit_vec(512), 512, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b1);
    chk("final_drain", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
